// File: rtl/regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arbiter
// Description : Write-port arbiter and scrub sequencer for the 32x32
//               three-port register file. Round-robin shares the single
//               write port (we3/wa3/wd3) among NREQ valid/ready requesters.
//               It can also run a sequenced clear of registers 1..2^AW-1.
// Ports       : clk         - rising-edge clock shared with the register file
//               reset       - asynchronous active-low reset
//               req_valid   - per-requester write request
//               req_addr    - requester i address at [i*AW +: AW]
//               req_data    - requester i data at [i*DW +: DW]
//               req_ready   - one-hot grant (combinational)
//               scrub_start - level-sampled request to clear the register file
//               we3/wa3/wd3 - registered register file write port
//               grant_id    - index of the last accepted requester
//               busy        - high while scrubbing
//               scrub_done  - one-cycle pulse after the last scrub write
// Options     : RF_ARB_SCRUB_EN - builds the SCRUB state, busy and scrub_done.
//               When undefined, scrub_start is ignored and busy/scrub_done
//               are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*DW-1:0]        req_data,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      scrub_start,
  output logic                      we3,
  output logic [AW-1:0]             wa3,
  output logic [DW-1:0]             wd3,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic                      scrub_done
);

  localparam int               c_IW   = $clog2(NREQ);
  localparam logic [c_IW-1:0]  c_LAST = c_IW'(NREQ - 1);
  localparam logic [NREQ-1:0]  c_ONE  = NREQ'(1);

  logic [c_IW-1:0] r_ptr;    // last granted requester
  logic [c_IW-1:0] w_cand;
  logic [c_IW-1:0] w_sel;
  logic            w_hit;
  logic            w_block;  // suppresses all grants (scrub entry / scrubbing)
  logic            w_xfer;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;

  // Round-robin search upward from ptr+1 with wrap. Only req_valid and ptr
  // feed this search, keeping req_addr/req_data off the ready path.
  always_comb begin
    w_cand = r_ptr;
    w_sel  = '0;
    w_hit  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = (w_cand == c_LAST) ? '0 : w_cand + c_IW'(1);
      if (!w_hit && req_valid[w_cand]) begin
        w_hit = 1'b1;
        w_sel = w_cand;
      end
    end
  end

  assign req_ready = (w_hit && !w_block) ? (c_ONE << w_sel) : '0;
  assign w_xfer    = w_hit && !w_block;
  assign w_addr    = req_addr[w_sel*AW +: AW];
  assign w_data    = req_data[w_sel*DW +: DW];

`ifdef RF_ARB_SCRUB_EN
  localparam logic [0:0] c_ARB   = 1'b0;
  localparam logic [0:0] c_SCRUB = 1'b1;

  logic [0:0] r_state;
  logic       r_done;

  // scrub_start wins over requests in ARB; nothing is granted while scrubbing.
  assign w_block    = (r_state == c_SCRUB) || scrub_start;
  assign busy       = (r_state == c_SCRUB);
  assign scrub_done = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ARB;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == c_SCRUB) begin
        // wa3 doubles as the scrub counter; all-ones is the final write.
        if (wa3 == '1) begin
          r_state <= c_ARB;
          r_done  <= 1'b1;
        end
      end else if (scrub_start) begin
        r_state <= c_SCRUB;
      end
    end
  end
`else
  logic w_unused_scrub;
  assign w_unused_scrub = scrub_start;
  assign w_block        = 1'b0;
  assign busy           = 1'b0;
  assign scrub_done     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      grant_id <= '0;
      r_ptr    <= c_LAST;
    end else begin
      we3 <= 1'b0;
`ifdef RF_ARB_SCRUB_EN
      if (r_state == c_SCRUB) begin
        wd3 <= '0;
        if (wa3 != '1) begin
          wa3 <= wa3 + AW'(1);
          we3 <= 1'b1;
        end
      end else if (scrub_start) begin
        wa3 <= AW'(1);
        wd3 <= '0;
        we3 <= 1'b1;
      end else
`endif
      if (w_xfer) begin
        wa3      <= w_addr;
        wd3      <= w_data;
        grant_id <= w_sel;
        r_ptr    <= w_sel;
        // x0 writes complete the handshake but never reach the file.
        we3      <= |w_addr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wr_arbiter
// Description : Directed self-checking bench for regfile_wr_arbiter with a
//               write-record scoreboard and a register file storage model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wr_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [19:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         scrub_start;
  logic         we3;
  logic [4:0]   wa3;
  logic [31:0]  wd3;
  logic [1:0]   grant_id;
  logic         busy;
  logic         scrub_done;

  regfile_wr_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .scrub_start(scrub_start),
    .we3(we3), .wa3(wa3), .wd3(wd3), .grant_id(grant_id), .busy(busy),
    .scrub_done(scrub_done)
  );

  always #5 clk = ~clk;

  // Storage model records any write, including x0, so a stray x0 write shows.
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge clk) if (we3) rf[wa3] <= wd3;

  typedef struct packed {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  gid;
  } wr_t;

  wr_t         sb[$];
  wr_t         held;
  logic [4:0]  a [4];
  logic [31:0] d [4];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          nb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] ad, input logic [31:0] da);
    a[i] = ad;
    d[i] = da;
    req_addr[i*5 +: 5]  = ad;
    req_data[i*32 +: 32] = da;
  endtask

  // Called at a negedge: drive, check the combinational grant, push the
  // expected write-port record, then compare it after the next edge.
  // scrub_wa != 0 means the next edge should produce a scrub write there.
  task automatic step(input logic [3:0] v, input logic s, input logic [3:0] rdy_exp,
                      input logic [4:0] scrub_wa);
    wr_t r;
    wr_t o;
    req_valid   = v;
    scrub_start = s;
    #1;
    chk("req_ready", req_ready, rdy_exp);
    r    = held;
    r.we = 1'b0;
    if (scrub_wa != 5'd0) begin
      r.we = 1'b1;
      r.wa = scrub_wa;
      r.wd = 32'h0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (rdy_exp[i]) begin
          r.wa  = a[i];
          r.wd  = d[i];
          r.gid = 2'(i);
          r.we  = (a[i] != 5'd0);
        end
      end
    end
    held = r;
    sb.push_back(r);
    @(negedge clk);
    o = sb.pop_front();
    chk("we3", we3, o.we);
    chk("wa3", wa3, o.wa);
    chk("wd3", wd3, o.wd);
    chk("grant_id", grant_id, o.gid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    req_valid   = 4'b0;
    scrub_start = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    held        = '0;
    for (int i = 0; i < 4; i++) set_req(i, 5'd0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_we3", we3, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scrub_done", scrub_done, 0);
    chk("rst_req_ready", req_ready, 0);
    reset = 1'b1;
    @(negedge clk);

    // Single write from requester 0 right after reset.
    set_req(0, 5'd5, 32'hA5A5A5A5);
    step(4'b0001, 1'b0, 4'b0001, 5'd0);
    step(4'b0000, 1'b0, 4'b0000, 5'd0);
    chk("rf5", rf[5], 32'hA5A5A5A5);

    // Requester 3 takes the last grant so the rotation then starts at 0.
    set_req(3, 5'd7, 32'h77777777);
    step(4'b1000, 1'b0, 4'b1000, 5'd0);
    for (int i = 0; i < 4; i++) set_req(i, 5'(16 + i), 32'hC0DE0000 + i);
    for (int c = 0; c < 8; c++) step(4'b1111, 1'b0, 4'(1 << (c % 4)), 5'd0);
    step(4'b0000, 1'b0, 4'b0000, 5'd0);
    chk("rf19", rf[19], 32'hC0DE0003);

    // Write to x0: accepted, not committed.
    set_req(2, 5'd0, 32'hFFFFFFFF);
    step(4'b0100, 1'b0, 4'b0100, 5'd0);
    step(4'b0000, 1'b0, 4'b0000, 5'd0);
    chk("rf0", rf[0], 32'h0);

`ifdef RF_ARB_SCRUB_EN
    // Full scrub with requester 1 waiting throughout.
    set_req(2, 5'd10, 32'h5A5A5A5A);
    step(4'b0100, 1'b0, 4'b0100, 5'd0);
    step(4'b0010, 1'b1, 4'b0000, 5'd1);
    nb = busy ? 1 : 0;
    for (int k = 1; k <= 30; k++) begin
      step(4'b0010, (k == 5), 4'b0000, 5'(k + 1));
      if (busy) nb++;
    end
    step(4'b0010, 1'b0, 4'b0000, 5'd0);
    chk("busy_cycles", nb, 31);
    chk("scrub_done_pulse", scrub_done, 1);
    chk("busy_after_scrub", busy, 0);
    step(4'b0010, 1'b0, 4'b0010, 5'd0);
    chk("scrub_done_clear", scrub_done, 0);
    chk("rf10_scrubbed", rf[10], 32'h0);
    chk("rf31_scrubbed", rf[31], 32'h0);

    // Reset in the middle of a scrub.
    set_req(0, 5'd13, 32'h13131313);
    step(4'b0001, 1'b0, 4'b0001, 5'd0);
    set_req(1, 5'd20, 32'h20202020);
    step(4'b0010, 1'b0, 4'b0010, 5'd0);
    step(4'b0000, 1'b1, 4'b0000, 5'd1);
    for (int k = 1; k <= 11; k++) step(4'b0000, 1'b0, 4'b0000, 5'(k + 1));
    reset = 1'b0;
    #1;
    chk("midrst_we3", we3, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_wa3", wa3, 0);
    held = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rf11_scrubbed", rf[11], 32'h0);
    chk("rf13_kept", rf[13], 32'h13131313);
    chk("rf20_kept", rf[20], 32'h20202020);
    step(4'b1111, 1'b0, 4'b0001, 5'd0);
    chk("busy_after_rst", busy, 0);
`else
    // Without the scrub option, scrub_start never blocks a grant.
    set_req(2, 5'd3, 32'h33333333);
    step(4'b0100, 1'b1, 4'b0100, 5'd0);
    chk("noscrub_busy", busy, 0);
    chk("noscrub_done", scrub_done, 0);
    step(4'b0000, 1'b1, 4'b0000, 5'd0);
    chk("noscrub_busy2", busy, 0);
    chk("rf3", rf[3], 32'h33333333);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Write-port arbiter and scrub sequencer for the 32x32 three-port register file. It shares the single write port (we3/wa3/wd3) among NREQ requesters using round-robin arbitration and a valid/ready handshake. It also provides an optional sequenced clear that zeroes registers 1..31. It sits directly in front of the register file, and its we3/wa3/wd3 outputs connect one-to-one to the register file's write port.

## Interface
- NREQ, 4, number of write requesters (2..8)
- AW, 5, register address width
- DW, 32, register data width
- clk  in  1  rising-edge clock, shared with the register file
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester write request
- req_addr  in  NREQ*AW  requester i address at bits [i*AW +: AW]
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant, combinational
- scrub_start  in  1  level-sampled request to clear the register file
- we3  out  1  register file write enable, registered
- wa3  out  AW  register file write address, registered
- wd3  out  DW  register file write data, registered
- grant_id  out  $clog2(NREQ)  index of the last accepted requester, registered
- busy  out  1  high while in SCRUB
- scrub_done  out  1  one-cycle pulse after the last scrub write

## Operation
- States: ARB and SCRUB. Reset enters ARB.
- ARB arbitration:
  - req_ready[i] = 1 only for the first valid requester found by searching upward, with wrap, from ptr+1.
  - ptr is the index of the last granted requester. It resets to NREQ-1, so requester 0 has top priority after reset.
- Handshake:
  - A transfer occurs at an edge where req_valid[i] and req_ready[i] are both high.
  - At that edge: wa3 <= req_addr[i], wd3 <= req_data[i], grant_id <= i, ptr <= i.
  - we3 <= 1, except we3 <= 0 when the address is 0. Writes to x0 are accepted and dropped.
  - A requester must hold valid, addr and data stable until it sees ready.
  - Deasserting valid before ready is permitted; the request is then dropped with no side effect.
- Idle cycles: with no transfer, we3 <= 0. wa3, wd3 and grant_id hold their values.
- Scrub entry: scrub_start high in ARB takes priority over requests.
  - All req_ready bits are 0 in that cycle.
  - At the edge: state <= SCRUB, wa3 <= 1, wd3 <= 0, we3 <= 1.
- SCRUB sequence:
  - All req_ready bits are 0. busy = 1.
  - wa3 increments by 1 each cycle from 1 to 2^AW-1; wd3 = 0 and we3 = 1 throughout.
  - At the edge leaving wa3 = 2^AW-1: state <= ARB, we3 <= 0, scrub_done <= 1 for one cycle.
  - wa3 is left at 2^AW-1. ptr is unchanged.
  - scrub_start is ignored while in SCRUB.
- Reset asserted at any time, including mid-scrub:
  - Immediately forces state = ARB, we3 = 0, wa3 = 0, wd3 = 0, grant_id = 0, scrub_done = 0, ptr = NREQ-1.
  - A partial scrub is abandoned and not resumed.

## Timing
- Reset values: we3 0, wa3 0, wd3 0, grant_id 0, busy 0, scrub_done 0. req_ready is 0 because no request is valid at reset.
- Accept-to-write latency: the handshake completes at edge N, the write-port outputs are valid during cycle N+1, and the register file commits at edge N+1.
- Throughput is one accepted write per cycle.
- With all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Scrub duration:
  - 2^AW-1 consecutive we3 cycles (31 for AW=5).
  - scrub_done is high in the cycle after the last we3 cycle.
  - The first request grant is possible in that same cycle.
- req_ready depends combinationally on req_valid, state, scrub_start and ptr. There are no paths from req_addr or req_data to req_ready.

## Configuration
- RF_ARB_SCRUB_EN defined:
  - The SCRUB state, the scrub counter, busy and scrub_done are built as described above.
- RF_ARB_SCRUB_EN undefined:
  - There is no SCRUB state, and scrub_start is ignored.
  - busy and scrub_done are tied to 0.
  - Arbitration is unchanged and scrub_start never blocks req_ready.

## Test plan
- Reset low, then release; req_valid=4'b0001, addr 5, data 32'hA5A5A5A5 -> req_ready=0001 in the same cycle; next cycle we3=1, wa3=5, wd3=A5A5A5A5, grant_id=0; a read of register 5 returns A5A5A5A5.
- req_valid=4'b1111 held 8 cycles, distinct addresses -> grant order 0,1,2,3,0,1,2,3 with exactly one ready bit per cycle and we3=1 every cycle.
- Requester 2 writes addr 0, data 32'hFFFFFFFF -> req_ready[2]=1, we3 stays 0, register 0 reads 0.
- Write 32'h5A5A5A5A to register 10, then pulse scrub_start with req_valid=4'b0010 held -> busy for 31 cycles, wa3 runs 1..31 with wd3=0, req_ready=0 throughout, then scrub_done pulses and requester 1 is granted that same cycle; register 10 reads 0.
- Drive reset low at scrub write 12, release 2 cycles later -> we3=0 and busy=0 immediately; registers 13..31 keep their prior values; the next grant goes to requester 0.
- Built without RF_ARB_SCRUB_EN, scrub_start=1 with req_valid=4'b0100 -> req_ready=0100; busy and scrub_done stay 0.
